// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: datapath widths, ALU opcode encoding and
// the operand-inversion classification used by the EX adder front end.
package rv32_pkg;

  localparam int WID_DATA = 32;
  localparam int WID_REG  = 5;
  localparam int WID_OP   = 4;

  typedef enum logic [WID_OP-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_CMP  = 4'd10
  } alu_op_e;

  // Ops that need x - y from the adder; it computes them as x + ~y + 1.
  function automatic logic is_sub_class(input logic [WID_OP-1:0] op);
    case (op)
      ALU_SUB, ALU_SLT, ALU_SLTU, ALU_CMP: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundle of ID-side, MEM/WB forwarding and EX-side signals around the
// ID/EX operand stage; slave = the stage, master = its environment.
interface ex_operand_stage_if
  import rv32_pkg::*;
#(
  parameter int W_DATA = WID_DATA,
  parameter int W_REG  = WID_REG,
  parameter int W_OP   = WID_OP
);
  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [W_DATA-1:0] id_pc;
  logic [W_DATA-1:0] id_rs1_data;
  logic [W_DATA-1:0] id_rs2_data;
  logic [W_DATA-1:0] id_imm;
  logic [W_REG-1:0]  id_rs1_addr;
  logic [W_REG-1:0]  id_rs2_addr;
  logic [W_REG-1:0]  id_rd_addr;
  logic [W_OP-1:0]   id_alu_op;
  logic              id_use_pc;
  logic              id_use_imm;
  logic              id_reg_write;
  logic              id_mem_read;
  logic [W_REG-1:0]  mem_rd_addr;
  logic              mem_reg_write;
  logic [W_DATA-1:0] mem_result;
  logic [W_REG-1:0]  wb_rd_addr;
  logic              wb_reg_write;
  logic [W_DATA-1:0] wb_result;
  logic [W_DATA-1:0] add_x;
  logic [W_DATA-1:0] add_y;
  logic              add_cin;
  logic              ex_valid;
  logic [W_OP-1:0]   ex_alu_op;
  logic [W_REG-1:0]  ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [W_DATA-1:0] ex_store_data;
  logic [W_DATA-1:0] ex_pc;
  logic              load_use_haz;

  modport slave (
    input  stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_use_pc,
           id_use_imm, id_reg_write, id_mem_read, mem_rd_addr, mem_reg_write,
           mem_result, wb_rd_addr, wb_reg_write, wb_result,
    output add_x, add_y, add_cin, ex_valid, ex_alu_op, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_store_data, ex_pc, load_use_haz
  );

  modport master (
    output stall, flush, id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op, id_use_pc,
           id_use_imm, id_reg_write, id_mem_read, mem_rd_addr, mem_reg_write,
           mem_result, wb_rd_addr, wb_reg_write, wb_result,
    input  add_x, add_y, add_cin, ex_valid, ex_alu_op, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_store_data, ex_pc, load_use_haz
  );

endinterface

// File: rtl/fwd_mux.sv
// Forwarding selector for one EX source operand: MEM result, then WB
// result, then the value latched from the register file. x0 is never bypassed.
module fwd_mux
  import rv32_pkg::*;
#(
  parameter int WID_DATA = rv32_pkg::WID_DATA,
  parameter int WID_REG  = rv32_pkg::WID_REG
) (
  input  logic [WID_REG-1:0]  src_addr_i,
  input  logic [WID_DATA-1:0] src_data_i,
  input  logic [WID_REG-1:0]  mem_rd_addr_i,
  input  logic                mem_reg_write_i,
  input  logic [WID_DATA-1:0] mem_result_i,
  input  logic [WID_REG-1:0]  wb_rd_addr_i,
  input  logic                wb_reg_write_i,
  input  logic [WID_DATA-1:0] wb_result_i,
  output logic [WID_DATA-1:0] fwd_data_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    fwd_data_o = src_data_i;
    if (src_addr_i != '0) begin
      if (mem_reg_write_i && (mem_rd_addr_i == src_addr_i)) begin
        fwd_data_o = mem_result_i;
      end else if (wb_reg_write_i && (wb_rd_addr_i == src_addr_i)) begin
        fwd_data_o = wb_result_i;
      end
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, adder operand preparation
// (subtract class as x + ~y + 1) and load-use hazard detection.
module ex_operand_stage
  import rv32_pkg::*;
#(
  parameter int WID_DATA = rv32_pkg::WID_DATA,
  parameter int WID_REG  = rv32_pkg::WID_REG,
  parameter int WID_OP   = rv32_pkg::WID_OP
) (
  input  logic              clk,
  input  logic              rst,
  ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                use_pc;
    logic                use_imm;
    logic [WID_OP-1:0]   alu_op;
    logic [WID_REG-1:0]  rs1_addr;
    logic [WID_REG-1:0]  rs2_addr;
    logic [WID_REG-1:0]  rd_addr;
    logic [WID_DATA-1:0] pc;
    logic [WID_DATA-1:0] rs1_data;
    logic [WID_DATA-1:0] rs2_data;
    logic [WID_DATA-1:0] imm;
  } idex_t;

  idex_t ex_d, ex_q;

  // Flush beats stall; a bubble clears the whole slot, not just the control bits.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (!bus.stall) begin
      ex_d.valid     = bus.id_valid;
      ex_d.reg_write = bus.id_valid & bus.id_reg_write;
      ex_d.mem_read  = bus.id_valid & bus.id_mem_read;
      ex_d.use_pc    = bus.id_use_pc;
      ex_d.use_imm   = bus.id_use_imm;
      ex_d.alu_op    = bus.id_alu_op;
      ex_d.rs1_addr  = bus.id_rs1_addr;
      ex_d.rs2_addr  = bus.id_rs2_addr;
      ex_d.rd_addr   = bus.id_rd_addr;
      ex_d.pc        = bus.id_pc;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.imm       = bus.id_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment for state; the whole slot resets so no stale operand survives.
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  logic [WID_DATA-1:0] fwd_rs1, fwd_rs2, op_a, op_b;
  logic                sub_class;

  fwd_mux #(.WID_DATA(WID_DATA), .WID_REG(WID_REG)) u_fwd_rs1 (
    .src_addr_i      (ex_q.rs1_addr),
    .src_data_i      (ex_q.rs1_data),
    .mem_rd_addr_i   (bus.mem_rd_addr),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_result_i    (bus.mem_result),
    .wb_rd_addr_i    (bus.wb_rd_addr),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_result_i     (bus.wb_result),
    .fwd_data_o      (fwd_rs1)
  );

  fwd_mux #(.WID_DATA(WID_DATA), .WID_REG(WID_REG)) u_fwd_rs2 (
    .src_addr_i      (ex_q.rs2_addr),
    .src_data_i      (ex_q.rs2_data),
    .mem_rd_addr_i   (bus.mem_rd_addr),
    .mem_reg_write_i (bus.mem_reg_write),
    .mem_result_i    (bus.mem_result),
    .wb_rd_addr_i    (bus.wb_rd_addr),
    .wb_reg_write_i  (bus.wb_reg_write),
    .wb_result_i     (bus.wb_result),
    .fwd_data_o      (fwd_rs2)
  );

  assign op_a      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign op_b      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign sub_class = is_sub_class(ex_q.alu_op);

  assign bus.add_x         = op_a;
  assign bus.add_y         = sub_class ? ~op_b : op_b;
  assign bus.add_cin       = sub_class;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_rd_addr    = ex_q.rd_addr;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.ex_pc         = ex_q.pc;

  // A load in EX whose rd is read by the instruction now in ID.
  assign bus.load_use_haz = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) &
                            ((ex_q.rd_addr == bus.id_rs1_addr) |
                             (ex_q.rd_addr == bus.id_rs2_addr));

endmodule
